// File: rtl/fifo_ro_param.sv
// -----------------------------------------------------------------------------
// fifo_ro_param
//
// Single-clock, show-ahead FIFO with req/ack handshakes on both sides, an
// arbitrary (non-power-of-two) depth, an occupancy count, almost-full /
// almost-empty flags and a synchronous flush.
//
// Parameters:
//   DW        data width in bits (>= 1)
//   DEPTH     number of entries (>= 2, any integer)
//   AF_LEVEL  almost_full  when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  almost_empty when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rstn          synchronous active-low reset (priority over flush)
//   d_in          write data
//   req_in        producer offers d_in
//   ack_in        FIFO can accept; a write happens on req_in & ack_in
//   d_out         head-of-FIFO data (show-ahead)
//   req_out       d_out valid (FIFO not empty)
//   ack_out       consumer takes d_out; a read happens on req_out & ack_out
//   flush         synchronous clear of pointers and count
//   count         occupancy, 0..DEPTH
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//
// Optional feature, macro FIFO_STAT_EN:
//   full_cnt      16-bit saturating count of cycles with a write blocked
//   empty_cnt     16-bit saturating count of cycles with a read on empty
//   Both clear on reset only; a flush leaves them untouched.
// -----------------------------------------------------------------------------
module fifo_ro_param #(
    parameter int DW       = 8,
    parameter int DEPTH    = 7,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [DW-1:0]              d_in,
    input  logic                       req_in,
    output logic                       ack_in,
    output logic [DW-1:0]              d_out,
    output logic                       req_out,
    input  logic                       ack_out,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
`ifdef FIFO_STAT_EN
    output logic [15:0]                full_cnt,
    output logic [15:0]                empty_cnt,
`endif
    output logic                       almost_full,
    output logic                       almost_empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);
    localparam logic [PW-1:0] LAST_C = PW'(DEPTH - 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          wr_en, rd_en;

    // Pointers wrap explicitly at DEPTH-1 so any depth works, not just 2^n.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    // Handshakes depend only on registered state plus rstn/flush, so a full
    // FIFO refuses a write even when a read is concurrent (no read-through).
    assign ack_in  = (count_q != FULL_C) & rstn & ~flush;
    assign req_out = (count_q != '0)     & rstn & ~flush;
    assign wr_en   = req_in  & ack_in;
    assign rd_en   = req_out & ack_out;

    assign d_out        = mem_q[rd_ptr_q];
    assign count        = count_q;
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
            unique case ({wr_en, rd_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; req_out masks stale entries,
    // and leaving it unreset lets the array map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= d_in;
    end

`ifdef FIFO_STAT_EN
    logic [15:0] full_cnt_q, empty_cnt_q;

    // rstn is already known high inside the else branch.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            full_cnt_q  <= '0;
            empty_cnt_q <= '0;
        end else begin
            if (req_in & ~ack_in & ~flush & ~&full_cnt_q)
                full_cnt_q <= full_cnt_q + 16'd1;
            if (ack_out & ~req_out & ~flush & ~&empty_cnt_q)
                empty_cnt_q <= empty_cnt_q + 16'd1;
        end
    end

    assign full_cnt  = full_cnt_q;
    assign empty_cnt = empty_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_ro_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_ro_param
//
// Self-checking bench for fifo_ro_param (DW=8, DEPTH=5, AF_LEVEL=4,
// AE_LEVEL=1). A driver applies directed and random stimulus shortly after
// each rising edge. A monitor on the falling edge compares the DUT against a
// queue-based reference model, pushes accepted writes into the scoreboard
// queue and pops/compares on every read handshake. The FIFO_STAT_EN counters
// are checked when that macro is defined.
// -----------------------------------------------------------------------------
module tb_fifo_ro_param;

    localparam int DW       = 8;
    localparam int DEPTH    = 5;
    localparam int AF_LEVEL = 4;
    localparam int AE_LEVEL = 1;
    localparam int CW       = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] d_in;
    logic          req_in;
    logic          ack_in;
    logic [DW-1:0] d_out;
    logic          req_out;
    logic          ack_out;
    logic          flush;
    logic [CW-1:0] count;
    logic          almost_full;
    logic          almost_empty;
`ifdef FIFO_STAT_EN
    logic [15:0]   full_cnt;
    logic [15:0]   empty_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [DW-1:0] model_q [$];
    int            m_full  = 0;
    int            m_empty = 0;
    int            max_seen = 0;
    int            pops = 0;

    fifo_ro_param #(
        .DW(DW), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .d_in         (d_in),
        .req_in       (req_in),
        .ack_in       (ack_in),
        .d_out        (d_out),
        .req_out      (req_out),
        .ack_out      (ack_out),
        .flush        (flush),
        .count        (count),
`ifdef FIFO_STAT_EN
        .full_cnt     (full_cnt),
        .empty_cnt    (empty_cnt),
`endif
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, then wait past the next rising edge.
    task automatic cyc(input logic r, input logic rq, input logic [DW-1:0] d,
                       input logic ak, input logic fl);
        rstn    = r;
        req_in  = rq;
        d_in    = d;
        ack_out = ak;
        flush   = fl;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare against the model, then advance the model by the
    // transfers the current (stable) inputs will cause at the next edge.
    initial begin
        logic exp_ack, exp_req;
        int   sz;
        forever begin
            @(negedge clk);
            sz      = model_q.size();
            exp_ack = rstn && !flush && (sz != DEPTH);
            exp_req = rstn && !flush && (sz != 0);
            check("ack_in",       32'(ack_in),       32'(exp_ack));
            check("req_out",      32'(req_out),      32'(exp_req));
            check("count",        32'(count),        32'(sz));
            check("almost_full",  32'(almost_full),  32'(sz >= AF_LEVEL));
            check("almost_empty", 32'(almost_empty), 32'(sz <= AE_LEVEL));
`ifdef FIFO_STAT_EN
            check("full_cnt",     32'(full_cnt),     32'(m_full));
            check("empty_cnt",    32'(empty_cnt),    32'(m_empty));
`endif
            if (int'(count) > max_seen) max_seen = int'(count);

            if (!rstn) begin
                model_q.delete();
                m_full  = 0;
                m_empty = 0;
            end else if (flush) begin
                model_q.delete();
            end else begin
                if (req_in && !exp_ack && m_full < 16'hFFFF)  m_full++;
                if (ack_out && !exp_req && m_empty < 16'hFFFF) m_empty++;
                if (exp_req && ack_out) begin
                    check("d_out", 32'(d_out), 32'(model_q[0]));
                    void'(model_q.pop_front());
                    pops++;
                end
                if (exp_ack && req_in) model_q.push_back(d_in);
            end
        end
    end

    initial begin
        // Reset held for 3 edges while the producer is requesting.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);

        // Fill 0x11..0x15, then a 6th offer that must be refused.
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 8'(8'h11 + i), 1'b0, 1'b0);

        // Full with concurrent read: only the read (0x11) happens; the
        // pending write is accepted on the following cycle.
        cyc(1'b1, 1'b1, 8'h16, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 8'h16, 1'b0, 1'b0);

        // Drain to 3, then flush with both sides requesting.
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("pops_before_flush", 32'(pops), 32'd3);

        // Stat scenario from a fresh reset: 2 empty reads, fill, 4 blocked
        // writes, then a flush (counters survive) and a reset (they clear).
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
`ifdef FIFO_STAT_EN
        check("full_cnt_4",  32'(full_cnt),  32'd4);
        check("empty_cnt_2", 32'(empty_cnt), 32'd2);
`endif
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef FIFO_STAT_EN
        check("full_cnt_flush",  32'(full_cnt),  32'd4);
        check("empty_cnt_flush", 32'(empty_cnt), 32'd2);
`endif
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef FIFO_STAT_EN
        check("full_cnt_rst",  32'(full_cnt),  32'd0);
        check("empty_cnt_rst", 32'(empty_cnt), 32'd0);
`endif

        // Random streaming with rare flushes and one mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            logic r, f;
            r = (i == 200) ? 1'b0 : 1'b1;
            f = ($urandom_range(0, 39) == 0);
            cyc(r, 1'($urandom_range(0, 2) != 0), 8'($urandom),
                1'($urandom_range(0, 2) != 0), f);
        end
        check("max_count", 32'(max_seen <= DEPTH), 32'd1);
        check("reached_full", 32'(max_seen), 32'(DEPTH));

        // Drain whatever is left so the remaining entries are compared.
        for (int i = 0; i < DEPTH + 2; i++) cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        check("drained", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_ro_param.md
Name: fifo_ro_param

Overview:
- Parametrised successor to the normal req/ack FIFO: synchronous, single-clock, show-ahead buffer with arbitrary (non-power-of-two) depth.
- Adds an occupancy count, almost-full/almost-empty flags and a synchronous flush.
- Sits between req/ack producer and consumer stages in datapath pipelines; the same handshake on both sides means it drops in wherever the normal FIFO is used.

Parameters:
- DW, 8, data width in bits (>=1).
- DEPTH, 7, number of entries (>=2, any integer, need not be power of two).
- AF_LEVEL, DEPTH-1, almost_full asserted when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- d_in  in  DW  write data.
- req_in  in  1  producer has valid d_in.
- ack_in  out  1  FIFO accepts; write occurs on req_in & ack_in.
- d_out  out  DW  head-of-FIFO data (show-ahead).
- req_out  out  1  d_out valid; FIFO not empty.
- ack_out  in  1  consumer takes d_out; read occurs on req_out & ack_out.
- flush  in  1  synchronous clear of contents.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.

Behaviour:
- Reset: clock is single; reset is synchronous and active-low (rstn sampled on rising edge of clk). After reset edge: wr_ptr=rd_ptr=0, count=0, req_out=0, ack_in=1, almost_full=0, almost_empty=1; d_out don't-care (no X-dependent control). While rstn=0, ack_in and req_out are forced 0.
- ack_in = (count != DEPTH) & rstn & ~flush; depends only on registered state plus rstn/flush, never on req_in.
- req_out = (count != 0) & rstn & ~flush; d_out = mem[rd_ptr], combinational from registered state.
- Write latency: entry written at edge N appears on d_out/req_out after edge N (1 cycle) if FIFO was empty; no write-through in the same cycle.
- Full: ack_in=0 even if a read is concurrent (no read-through); the freed slot is visible next cycle.
- Simultaneous read+write (neither full nor empty): both happen, count unchanged, pointers both advance.
- Pointer wrap: pointer == DEPTH-1 advances to 0; correct for non-power-of-two DEPTH.
- count: +1 on write only, -1 on read only, unchanged otherwise; never exceeds DEPTH or goes below 0.
- flags: combinational from registered count; change in the same cycle as count.
- flush=1 at edge: pointers and count cleared to 0; concurrent handshakes are suppressed (ack_in/req_out low), so no data are lost mid-transfer from either side's view. Memory contents are not cleared.
- Reset mid-operation: all contents discarded, same state as a flush; rstn has priority over flush.

Optional Feature:
- Macro FIFO_STAT_EN.
- Defined: adds outputs full_cnt and empty_cnt (each 16 bits). full_cnt increments on each cycle with req_in & ~ack_in & rstn & ~flush. empty_cnt increments on each cycle with ack_out & ~req_out & rstn & ~flush. Both saturate at 16'hFFFF and clear on reset only, not on flush.
- Undefined: ports and counters absent; the rest of the behaviour is identical.

Test Plan:
- Reset, then DW=8, DEPTH=5: hold rstn=0 for 3 edges with req_in=1 -> ack_in=0, req_out=0. After release: count=0, almost_empty=1, ack_in=1.
- Fill: write 0x11..0x15 with ack_out=0 -> count 1..5, ack_in=0 after 5th write, almost_full=1 at count 4 (AF_LEVEL=4). A 6th req_in is not accepted.
- Full + read: at count=5 assert req_in=1, ack_out=1 -> only the read occurs (d_out=0x11), count=4. The write is accepted the next cycle.
- Wrap: stream 20 random bytes with random req_in/ack_out -> output order matches the scoreboard, pointers wrap past index 4, count never exceeds 5.
- Flush: at count=3 pulse flush with req_in=1, ack_out=1 -> ack_in=0 and req_out=0 that cycle; next cycle count=0, req_out=0, no pop recorded.
- FIFO_STAT_EN: 4 blocked-write cycles and 2 empty-read cycles -> full_cnt=4, empty_cnt=2. Both counts survive a flush and clear on reset.
